// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI4-Stream constants, a maximum-width beat type and a width helper.
package axis_pkg;

    localparam int unsigned AXIS_MAX_DATA_W = 512;
    localparam int unsigned AXIS_MAX_KEEP_W = AXIS_MAX_DATA_W / 8;

    // Widest beat any stream in this codebase may carry; blocks narrow it locally.
    typedef struct packed {
        logic [AXIS_MAX_DATA_W-1:0] tdata;
        logic [AXIS_MAX_KEEP_W-1:0] tkeep;
        logic                       tlast;
    } axis_beat_max_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned axis_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port beat storage, one write port and one read port whose
// address is registered; read data follows the registered address combinationally. No reset.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH   = 37,
    parameter int unsigned ENTRIES = 15,
    parameter int unsigned ADDR_W  = axis_clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0]  r_mem [ENTRIES];
    logic [ADDR_W-1:0] r_rd_addr;

    // Write port and read-address register.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_addr <= i_rd_addr;
    end

    assign o_rd_data = r_mem[r_rd_addr];

endmodule

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: AXI4-Stream FIFO of DEPTH beats (DEPTH-1 RAM entries plus an output
// register) with first-word fall-through, bypass when the RAM is empty, registered
// s_axis_tready and a fill level. Defining AXIS_FIFO_PKT_MODE_EN selects store-and-forward.
module axis_stream_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LVL_W  = axis_clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [LVL_W-1:0]    level,
    output logic                full,
    output logic                empty
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned PTR_W  = axis_clog2(DEPTH);
    localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
    } beat_t;

    logic             r_s_ready;
    logic             r_out_valid;
    beat_t            r_out_beat;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_ram_cnt;
    logic [LVL_W-1:0] r_level;

    beat_t            w_in_beat;
    beat_t            w_ram_beat;
    logic             w_push;
    logic             w_pop;
    logic             w_release;
    logic             w_out_free;
    logic             w_load_ram;
    logic             w_bypass;
    logic             w_ram_wr;
    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic [LVL_W-1:0] w_ram_cnt_d;
    logic [LVL_W-1:0] w_level_d;

    // RAM holds DEPTH-1 entries, so pointers wrap explicitly rather than by overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 2)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_in_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};

    assign w_push     = s_axis_tvalid & r_s_ready;
    assign w_pop      = m_axis_tvalid & m_axis_tready;
    // The output register is empty only when the RAM is empty, so the RAM is drained first.
    assign w_out_free = ~r_out_valid | w_pop;
    assign w_load_ram = w_out_free & (r_ram_cnt != '0);
    assign w_bypass   = w_out_free & (r_ram_cnt == '0) & w_push;
    assign w_ram_wr   = w_push & ~w_bypass;

    // Next-state pointers and counters.
    always_comb begin
        w_wr_ptr_d  = w_ram_wr ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_d  = w_load_ram ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_ram_cnt_d = r_ram_cnt + LVL_W'(w_ram_wr) - LVL_W'(w_load_ram);
        w_level_d   = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end

    // The read address is fed the next pointer so the registered RAM address tracks r_rd_ptr.
    axis_fifo_ram #(
        .WIDTH   (BEAT_W),
        .ENTRIES (DEPTH - 1),
        .ADDR_W  (PTR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_in_beat),
        .i_rd_addr (w_rd_ptr_d),
        .o_rd_data (w_ram_beat)
    );

    // Control state: pointers, counts and the registered upstream ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_level   <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_d;
            r_rd_ptr  <= w_rd_ptr_d;
            r_ram_cnt <= w_ram_cnt_d;
            r_level   <= w_level_d;
            r_s_ready <= (w_level_d < LVL_W'(DEPTH));
        end
    end

    // Output register: refill from RAM, else straight from the input when the RAM is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_out_free) begin
            r_out_valid <= w_load_ram | w_bypass;
            if (w_load_ram) begin
                r_out_beat <= w_ram_beat;
            end else if (w_bypass) begin
                r_out_beat <= w_in_beat;
            end
        end
    end

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [LVL_W-1:0] r_pkt_cnt;

    // Count of complete packets buffered; each tlast in or out moves it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pkt_cnt <= '0;
        end else begin
            r_pkt_cnt <= r_pkt_cnt + LVL_W'(w_push & s_axis_tlast)
                                   - LVL_W'(w_pop & r_out_beat.tlast);
        end
    end

    // Full forces release so packets longer than DEPTH cannot deadlock.
    assign w_release = (r_pkt_cnt != '0) | full;
`else
    assign w_release = 1'b1;
`endif

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_out_valid & w_release;
    assign m_axis_tdata  = r_out_beat.tdata;
    assign m_axis_tkeep  = r_out_beat.tkeep;
    assign m_axis_tlast  = r_out_beat.tlast;
    assign level         = r_level;
    assign full          = (r_level == LVL_W'(DEPTH));
    assign empty         = (r_level == '0);

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo: queue-based reference model with a per-cycle compare process,
// randomized source/sink duty cycles and directed checks with hand-computed literals.
module tb_axis_stream_fifo;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned LVL_W  = 5;

    typedef logic [DATA_W+KEEP_W:0] beat_t;  // {tdata, tkeep, tlast}

    logic              clk;
    logic              rstn;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;

    axis_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level),
        .full          (full),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t       tx_q[$];
    beat_t       model_q[$];
    beat_t       stall_beat;
    beat_t       popped;
    int          checks = 0;
    int          errors = 0;
    int unsigned src_duty = 100;
    int unsigned snk_duty = 100;
    bit          gap_en = 0;
    bit          stall_prev = 0;
    bit          exp_ready = 0;
    bit          acc;
    int          cycle = 0;
    int          rx_count = 0;
    int          push_count = 0;
    int          tlast_rx = 0;
    int          max_level = 0;
    int          first_pop_cycle = -1;
    int          last_pop_cycle = 0;
    int          tlast_push_cycle = 0;
    int          level_at_first_pop = 0;
    logic [31:0] last_rx_data = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pkts_in_model();
        int n = 0;
        foreach (model_q[i]) if (model_q[i][0]) n++;
        return n;
    endfunction

    // Reference model: queue of beats held, updated on each handshake.
    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            model_q.delete();
            exp_ready  = 0;
            stall_prev = 0;
        end else begin
            cycle++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (first_pop_cycle < 0) begin
                    first_pop_cycle    = cycle;
                    level_at_first_pop = model_q.size();
                end
                last_pop_cycle = cycle;
                if (model_q.size() > 0) popped = model_q.pop_front();
                rx_count++;
                last_rx_data = m_axis_tdata;
                if (m_axis_tlast) tlast_rx++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                model_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast});
                push_count++;
                if (s_axis_tlast) tlast_push_cycle = cycle;
            end
            exp_ready = (model_q.size() < DEPTH);
            if (model_q.size() > max_level) max_level = model_q.size();
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        bit exp_valid;
        @(negedge clk);
`ifdef AXIS_FIFO_PKT_MODE_EN
        exp_valid = (model_q.size() > 0) && ((pkts_in_model() > 0) || (model_q.size() == DEPTH));
`else
        exp_valid = (model_q.size() > 0);
`endif
        chk("level", level, model_q.size());
        chk("full", full, model_q.size() == DEPTH);
        chk("empty", empty, model_q.size() == 0);
        chk("s_tready", s_axis_tready, exp_ready);
        chk("m_tvalid", m_axis_tvalid, exp_valid);
        if (m_axis_tvalid && model_q.size() > 0) begin
            chk("payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, model_q[0]);
        end
        if (stall_prev && rstn) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, stall_beat);
        end
    end

    // Source and sink drivers; a source beat is held until accepted.
    initial forever begin
        @(posedge clk);
        acc = s_axis_tvalid && s_axis_tready;
        #1;
        if (acc) void'(tx_q.pop_front());
        if (acc && gap_en) begin
            s_axis_tvalid = 1'b0;
        end else if (!s_axis_tvalid || acc) begin
            if (tx_q.size() > 0 && $urandom_range(99) < src_duty) begin
                s_axis_tvalid = 1'b1;
                {s_axis_tdata, s_axis_tkeep, s_axis_tlast} = tx_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
        m_axis_tready = ($urandom_range(99) < snk_duty);
    end

    task automatic wait_rx(input int target, input int budget, input string name);
        int n = 0;
        while (rx_count < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, rx_count >= target, 1);
    endtask

    initial begin
        int  base;
        int  base_push;
        int  tl_base;
        int  n;
        bit  hit;
        rstn          = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        rstn = 1'b1;
        @(posedge clk);
        #2;
        chk("tready_after_rst", s_axis_tready, 1);

        // Sequential 0..19, sink always ready.
        max_level = 0;
        base      = rx_count;
        tl_base   = tlast_rx;
        for (int i = 0; i < 20; i++) tx_q.push_back({32'(i), 4'hF, (i == 19)});
        n   = 0;
        hit = 0;
        while (!hit && n < 50) begin
            @(posedge clk);
            hit = s_axis_tvalid && s_axis_tready;
            n++;
        end
        chk("t1_first_accept", hit, 1);
        #2;
`ifndef AXIS_FIFO_PKT_MODE_EN
        chk("t1_latency_valid", m_axis_tvalid, 1);
        chk("t1_latency_data", m_axis_tdata, 0);
`endif
        wait_rx(base + 20, 300, "t1_drain");
`ifndef AXIS_FIFO_PKT_MODE_EN
        chk("t1_max_level", max_level, 1);
`endif
        chk("t1_tlast_count", tlast_rx - tl_base, 1);
        chk("t1_last_data", last_rx_data, 19);

        // Fill to full with the sink stalled, then drain.
        snk_duty = 0;
        @(posedge clk);
        #2;
        base      = rx_count;
        base_push = push_count;
        for (int i = 0; i < 20; i++) tx_q.push_back({32'(100 + i), 4'hF, (i == 19)});
        repeat (40) @(posedge clk);
        #2;
        chk("t2_level", level, 16);
        chk("t2_full", full, 1);
        chk("t2_tready", s_axis_tready, 0);
        chk("t2_accepted", push_count - base_push, 16);
        chk("t2_pending", tx_q.size(), 4);
        snk_duty = 100;
        wait_rx(base + 20, 300, "t2_drain");
        chk("t2_total_accepted", push_count - base_push, 20);
        chk("t2_last_data", last_rx_data, 119);

        // Random traffic at 30% duty on both sides.
        src_duty = 30;
        snk_duty = 30;
        base     = rx_count;
        for (int i = 0; i < 1000; i++) begin
            tx_q.push_back({32'($urandom), 4'($urandom), (i == 999) || ($urandom_range(7) == 0)});
        end
        wait_rx(base + 1000, 20000, "t3_drain");
        chk("t3_count", rx_count - base, 1000);

        // Asynchronous reset with seven beats held.
        src_duty = 100;
        snk_duty = 0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) tx_q.push_back({32'(200 + i), 4'hF, (i == 9)});
        n = 0;
        while (model_q.size() != 7 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t4_level7", level, 7);
        #1;
        rstn = 1'b0;
        #1;
        chk("t4_rst_tvalid", m_axis_tvalid, 0);
        chk("t4_rst_level", level, 0);
        chk("t4_rst_empty", empty, 1);
        chk("t4_rst_tready", s_axis_tready, 0);
        repeat (2) @(posedge clk);
        #3;
        base = rx_count;
        rstn = 1'b1;
        #1;
        chk("t4_tready_low_at_release", s_axis_tready, 0);
        @(posedge clk);
        #2;
        chk("t4_tready_after_edge", s_axis_tready, 1);
        snk_duty = 100;
        wait_rx(base + 3, 100, "t4_drain");
        chk("t4_post_count", rx_count - base, 3);
        chk("t4_last_data", last_rx_data, 209);

`ifdef AXIS_FIFO_PKT_MODE_EN
        // Store-and-forward: 4-beat packet with idle gaps.
        repeat (5) @(posedge clk);
        #2;
        gap_en          = 1;
        first_pop_cycle = -1;
        base            = rx_count;
        for (int i = 0; i < 4; i++) tx_q.push_back({32'(300 + i), 4'hF, (i == 3)});
        wait_rx(base + 4, 100, "t5_drain");
        gap_en = 0;
        chk("t5_release_delay", first_pop_cycle - tlast_push_cycle, 1);
        chk("t5_back_to_back", last_pop_cycle - first_pop_cycle, 3);

        // Packet longer than DEPTH must release at full.
        repeat (5) @(posedge clk);
        #2;
        first_pop_cycle = -1;
        base            = rx_count;
        for (int i = 0; i < 40; i++) tx_q.push_back({32'(400 + i), 4'hF, (i == 39)});
        wait_rx(base + 40, 1000, "t6_drain");
        chk("t6_count", rx_count - base, 40);
        chk("t6_start_at_full", level_at_first_pop, 16);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_stream_fifo.md
# axis_stream_fifo

Parametrised AXI4-Stream buffering stage that replaces the fixed 32-bit pass-through between an upstream stream master and downstream consumer. Stores up to DEPTH beats with TDATA/TKEEP/TLAST, fully decouples both handshakes with registered ready and valid, and reports fill level. Optional store-and-forward packet mode holds output until a whole packet is buffered.

## Interface
- DATA_W, 32, TDATA width in bits; multiple of 8, 8..512
- DEPTH, 16, storage capacity in beats; power of 2, 4..1024
- LVL_W, $clog2(DEPTH)+1, width of level output (derived, not overridden)
- clk  in  1  clock, all logic rising-edge
- rstn  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tready  out  1  upstream beat accepted when high with tvalid
- s_axis_tdata  in  DATA_W  upstream data
- s_axis_tkeep  in  DATA_W/8  upstream byte enables
- s_axis_tlast  in  1  upstream end of packet
- m_axis_tvalid  out  1  downstream beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_W  downstream data
- m_axis_tkeep  out  DATA_W/8  downstream byte enables
- m_axis_tlast  out  1  downstream end of packet
- level  out  LVL_W  beats held (RAM plus output register), 0..DEPTH
- full, empty  out  1 each  level==DEPTH, level==0

## Operation
- Push: s_axis_tvalid & s_axis_tready at rising edge; pop: m_axis_tvalid & m_axis_tready.
- Circular RAM of DEPTH-1 entries plus one output register; wr/rd pointers log2(DEPTH) bits, wrap modulo DEPTH-1 handled by explicit compare (no power-of-2 wrap on RAM).
- First-word fall-through: when output register empty or being popped, next beat loads from RAM, or directly from input if RAM empty (bypass).
- Beat order and TKEEP/TLAST preserved exactly; no beat created, dropped or merged.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- s_axis_tready registered: next-cycle value = (level_next < DEPTH). No combinational path m_axis_tready -> s_axis_tready.
- Full with simultaneous pop: tready low that cycle, push impossible; tready rises next cycle.
- Empty: m_axis_tvalid low; m_axis_tdata/tkeep/tlast hold last popped values (don't-care to checker).
- Once m_axis_tvalid high, it and payload stay stable until popped (AXI rule).

## Timing
- Reset (rstn low, async): m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, level=0, full=0, empty=1, pointers 0. RAM not cleared.
- s_axis_tready rises on first rising edge after rstn deasserts.
- Latency: beat pushed at edge N appears on m_axis with tvalid high after edge N (one cycle) when empty.
- Throughput: one beat/cycle sustained with both sides always ready, including at full and across pointer wrap.
- Reset mid-packet: all buffered beats discarded; no partial packet emitted after reset.

## Configuration
- AXIS_FIFO_PKT_MODE_EN defined: store-and-forward. Internal packet counter (LVL_W bits) +1 on push with tlast, -1 on pop with tlast. m_axis_tvalid asserted only when packet counter > 0 or full (full forces cut-through release to avoid deadlock on packets longer than DEPTH). Adds one cycle latency: tvalid earliest one cycle after the tlast beat is pushed.
- Not defined: cut-through as above; packet counter logic absent.

## Structure
- Shared package axis_pkg: AXIS_MAX_DATA_W constant, beat struct typedef (tdata, tkeep, tlast) parametrised via localparam widths, clog2 helper function.
- One sub-module: axis_fifo_ram (simple dual-port, one write port, one registered-address read port, no reset) holding the beat struct; control, pointers, bypass and output register stay in axis_stream_fifo.

## Test plan
- Reset then push 0..19 (tlast on 19, tkeep all ones), m_axis_tready=1 -> 20 beats out in order, first one cycle after first push, tlast only on 19, level never exceeds 1.
- DEPTH=16, m_axis_tready=0, push 20 beats -> 16 accepted, s_axis_tready=0 after 16th, full=1, level=16; release ready -> 16 beats out 0..15, then remaining 4 accepted.
- Random 30%-duty valid/ready, 1000 beats with random tkeep -> scoreboard exact match, tvalid/tdata stable while stalled, level equals outstanding count every cycle.
- Assert rstn low mid-stream at level=7 -> next cycle m_axis_tvalid=0, level=0, empty=1; tready 1 one edge after release; later beats flow unaffected.
- AXIS_FIFO_PKT_MODE_EN: push 4-beat packet with one idle cycle between beats -> m_axis_tvalid stays 0 until one cycle after beat 4 pushed, then 4 back-to-back beats.
- AXIS_FIFO_PKT_MODE_EN, DEPTH=16: 40-beat packet, ready=1 -> output starts at full, all 40 beats delivered, no deadlock.
